// File: rtl/fft_frame_packetizer.sv
// Frames a non-stallable complex sample stream into FFT_POINTS-sample Avalon-ST packets.
// Frames are admitted whole into an internal FIFO or dropped whole; output honours ready.
module fft_frame_packetizer #(
  parameter int INPUT_SYMBOL_WIDTH = 16,
  parameter int FFT_POINTS         = 1024,
  parameter int FIFO_DEPTH         = 2048,
  parameter int DROP_CNT_WIDTH     = 16
) (
  input  logic                              clock_clk,
  input  logic                              reset_reset_n,
  input  logic [2*INPUT_SYMBOL_WIDTH-1:0]   asi_in_data,
  input  logic                              asi_in_valid,
  input  logic                              cfg_enable,
  output logic [2*INPUT_SYMBOL_WIDTH-1:0]   aso_out_data,
  output logic                              aso_out_valid,
  output logic                              aso_out_startofpacket,
  output logic                              aso_out_endofpacket,
  input  logic                              aso_out_ready,
  output logic [DROP_CNT_WIDTH-1:0]         stat_frames_dropped,
  output logic [$clog2(FIFO_DEPTH):0]       stat_fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FFT_POINTS);
  localparam int DW = 2*INPUT_SYMBOL_WIDTH;
  localparam logic [AW+1:0] DEPTH_F  = (AW+2)'(FIFO_DEPTH);
  localparam logic [AW+1:0] POINTS_F = (AW+2)'(FFT_POINTS);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST     = CW'(FFT_POINTS-1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [DW-1:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [AW:0]               level;
  logic [CW-1:0]             in_cnt, out_cnt;
  logic [1:0]                state;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;
  logic [AW+1:0]             free;
  logic                      pop, push, admit, frame_end;

  assign aso_out_valid = (level != '0);
  assign pop           = aso_out_valid && aso_out_ready;
  // Space freed by this cycle's pop counts toward admitting a new frame.
  assign free          = DEPTH_F - {1'b0, level} + {{(AW+1){1'b0}}, pop};
  assign admit         = (free >= POINTS_F);
  assign frame_end     = (in_cnt == LAST);
  assign push          = asi_in_valid &&
                         (((state == IDLE) && cfg_enable && admit) || (state == WRITE));

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      in_cnt   <= '0;
      drop_cnt <= '0;
    end else if (asi_in_valid) begin
      case (state)
        IDLE: begin
          if (cfg_enable) begin
            in_cnt <= CW'(1);
            if (admit) begin
              state <= WRITE;
            end else begin
              state <= DROP;
              if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
          end
        end
        WRITE, DROP: begin
          in_cnt <= in_cnt + 1'b1;
          if (frame_end) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          in_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      out_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        out_cnt <= out_cnt + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock_clk) begin
    if (push) mem[wr_ptr] <= asi_in_data;
  end

  // Data is forced to zero while empty so reset drives every output low.
  assign aso_out_data          = aso_out_valid ? mem[rd_ptr] : '0;
  assign aso_out_startofpacket = aso_out_valid && (out_cnt == '0);
  assign aso_out_endofpacket   = aso_out_valid && (out_cnt == LAST);
  assign stat_frames_dropped   = drop_cnt;
  assign stat_fifo_level       = level;

  no_write_when_full: assert property (@(posedge clock_clk) disable iff (!reset_reset_n)
                                       !(push && (level == DEPTH_L)));

endmodule

// File: tb/tb_fft_frame_packetizer.sv
// Directed bench for fft_frame_packetizer with 8-point frames, 16-entry FIFO, 2-bit drop counter.
module tb_fft_frame_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        enable;
  logic [31:0] out_data;
  logic        out_valid, out_sop, out_eop, out_ready;
  logic [1:0]  dropped;
  logic [4:0]  level;

  int errors = 0;
  int checks = 0;
  logic [33:0] obs[$];
  int gap_cnt;

  fft_frame_packetizer #(
    .INPUT_SYMBOL_WIDTH(16), .FFT_POINTS(8), .FIFO_DEPTH(16), .DROP_CNT_WIDTH(2)
  ) dut (
    .clock_clk(clk), .reset_reset_n(rst_n),
    .asi_in_data(in_data), .asi_in_valid(in_valid), .cfg_enable(enable),
    .aso_out_data(out_data), .aso_out_valid(out_valid),
    .aso_out_startofpacket(out_sop), .aso_out_endofpacket(out_eop),
    .aso_out_ready(out_ready),
    .stat_frames_dropped(dropped), .stat_fifo_level(level)
  );

  always #5 clk = ~clk;

  // Record every accepted output beat; count empty cycles inside a packet.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) obs.push_back({out_data, out_sop, out_eop});
      if (!out_valid && (obs.size() % 8) != 0) gap_cnt++;
    end
  end

  function automatic logic [31:0] exp_dat(input int v);
    logic [15:0] re, im;
    re = 16'(v);
    im = 16'(v) ^ 16'hA5A5;
    return {re, im};
  endfunction

  function automatic logic [33:0] exp_beat(input int v, input int pos);
    return {exp_dat(v), (pos % 8) == 0, (pos % 8) == 7};
  endfunction

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    obs.delete();
    gap_cnt = 0;
  endtask

  task automatic send(input int base, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 in_valid = 1'b1;
      in_data = exp_dat(base + i);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    for (int c = 0; c < 100 && obs.size() < n; c++) @(posedge clk);
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    apply_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, out_sop, out_eop, out_data, dropped, level} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b s=%b e=%b d=%h drop=%0d lvl=%0d want all 0",
               out_valid, out_sop, out_eop, out_data, dropped, level);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = exp_dat(0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_latency_early got valid=%b want 0", out_valid);
    end
    for (int i = 1; i < 24; i++) begin
      @(posedge clk);
      #1 in_data = exp_dat(i);
      if (i == 1) begin
        @(negedge clk);
        checks++;
        if ({out_valid, out_sop, out_data} !== {2'b11, exp_dat(0)}) begin
          errors++;
          $display("FAIL stream_first_out got v=%b sop=%b d=%h want v=1 sop=1 d=%h",
                   out_valid, out_sop, out_data, exp_dat(0));
        end
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_obs(24);
    checks++;
    if (obs.size() != 24) begin
      errors++;
      $display("FAIL stream_count got %0d want 24", obs.size());
    end
    for (int i = 0; i < 24 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_beat(i, i)) begin
        errors++;
        $display("FAIL stream_beat[%0d] got %h want %h", i, obs[i], exp_beat(i, i));
      end
    end
    checks++;
    if (dropped !== 2'd0) begin
      errors++;
      $display("FAIL stream_dropped got %0d want 0", dropped);
    end
  endtask

  task automatic test_overflow_drop();
    apply_reset();
    out_ready = 1'b0;
    send(0, 40, 0);
    checks++;
    if (level !== 5'd16 || dropped !== 2'd3) begin
      errors++;
      $display("FAIL drop_stats got level=%0d dropped=%0d want 16 and 3", level, dropped);
    end
    send(40, 8, 0);
    checks++;
    if (dropped !== 2'd3) begin
      errors++;
      $display("FAIL drop_saturate got %0d want 3", dropped);
    end
    checks++;
    if (obs.size() != 0) begin
      errors++;
      $display("FAIL drop_stalled_out got %0d beats want 0", obs.size());
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_obs(16);
    checks++;
    if (obs.size() != 16 || level !== 5'd0) begin
      errors++;
      $display("FAIL drop_drain got %0d beats level=%0d want 16 beats level 0", obs.size(), level);
    end
    for (int i = 0; i < 16 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_beat(i, i)) begin
        errors++;
        $display("FAIL drop_beat[%0d] got %h want %h", i, obs[i], exp_beat(i, i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] held;
    apply_reset();
    out_ready = 1'b0;
    send(0, 8, 0);
    held = '0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1 out_ready = (k % 2 == 0);
      @(negedge clk);
      if (k % 2 == 1) held = {out_data, out_sop, out_eop};
      else if (k > 0) begin
        checks++;
        if ({out_data, out_sop, out_eop} !== held) begin
          errors++;
          $display("FAIL bp_stable[%0d] got %h want %h", k, {out_data, out_sop, out_eop}, held);
        end
      end
    end
    out_ready = 1'b1;
    wait_obs(8);
    checks++;
    if (obs.size() != 8) begin
      errors++;
      $display("FAIL bp_count got %0d want 8", obs.size());
    end
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_beat(i, i)) begin
        errors++;
        $display("FAIL bp_beat[%0d] got %h want %h", i, obs[i], exp_beat(i, i));
      end
    end
  endtask

  task automatic test_enable();
    apply_reset();
    out_ready = 1'b1;
    enable = 1'b1;
    send(0, 3, 0);
    enable = 1'b0;
    send(3, 5, 0);
    send(100, 5, 0);
    enable = 1'b1;
    send(200, 8, 0);
    wait_obs(16);
    checks++;
    if (obs.size() != 16 || dropped !== 2'd0) begin
      errors++;
      $display("FAIL en_count got %0d beats dropped=%0d want 16 and 0", obs.size(), dropped);
    end
    for (int i = 0; i < 16 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_beat(i < 8 ? i : 192 + i, i)) begin
        errors++;
        $display("FAIL en_beat[%0d] got %h want %h", i, obs[i], exp_beat(i < 8 ? i : 192 + i, i));
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b0;
    send(0, 8, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if ({out_valid, out_sop, out_data} !== {2'b10, exp_dat(4)}) begin
      errors++;
      $display("FAIL arst_midpkt got v=%b sop=%b d=%h want v=1 sop=0 d=%h",
               out_valid, out_sop, out_data, exp_dat(4));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sop, out_eop, out_data, level} !== '0) begin
      errors++;
      $display("FAIL arst_outputs got v=%b s=%b e=%b d=%h lvl=%0d want all 0",
               out_valid, out_sop, out_eop, out_data, level);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    obs.delete();
    out_ready = 1'b1;
    send(50, 8, 0);
    wait_obs(8);
    checks++;
    if (obs.size() != 8) begin
      errors++;
      $display("FAIL arst_count got %0d want 8", obs.size());
    end
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_beat(50 + i, i)) begin
        errors++;
        $display("FAIL arst_beat[%0d] got %h want %h", i, obs[i], exp_beat(50 + i, i));
      end
    end
  endtask

  task automatic test_gapped();
    apply_reset();
    out_ready = 1'b1;
    send(300, 16, 2);
    wait_obs(16);
    checks++;
    if (obs.size() != 16 || gap_cnt == 0) begin
      errors++;
      $display("FAIL gap_count got %0d beats gaps=%0d want 16 beats and gaps>0", obs.size(), gap_cnt);
    end
    for (int i = 0; i < 16 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_beat(300 + i, i)) begin
        errors++;
        $display("FAIL gap_beat[%0d] got %h want %h", i, obs[i], exp_beat(300 + i, i));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    enable = 1'b1;
    out_ready = 1'b1;
    test_reset();
    test_stream();
    test_overflow_drop();
    test_backpressure();
    test_enable();
    test_async_reset();
    test_gapped();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
